// File: rtl/packet_framer.sv
// Packet framer: buffers packer bytes in a FIFO and emits SYNC, LEN, payload, CHK frames.
// Build option FRAMER_CRC8_EN selects a CRC-8 CHK byte instead of the XOR checksum.
module packet_framer #(
  parameter int          FIFO_DEPTH = 32,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_in_valid,
  input  logic       packet_end,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  typedef enum logic [2:0] {ST_IDLE, ST_SYNC, ST_LEN, ST_DATA, ST_CHK} state_t;

  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, commit_ptr, rd_ptr, rd_next;
  logic [7:0] pend_len, pend_chk;
  logic       pend_bad;
  logic       desc_valid;
  logic [7:0] desc_len, desc_chk;
  state_t     state;
  logic [7:0] cnt, out_len;
`ifdef FRAMER_CRC8_EN
  logic [7:0] crc;

  function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    return r;
  endfunction
`else
  logic [7:0] out_chk;
`endif

  logic       full, byte_acc, bad_next, drop, commit, hs, desc_take;
  logic [7:0] len_next, chk_next;

  always_comb begin
    full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    byte_acc  = byte_in_valid & ~full;
    len_next  = pend_len + {7'd0, byte_acc};
    chk_next  = pend_chk ^ (byte_acc ? byte_in : 8'd0);
    bad_next  = pend_bad | (byte_in_valid & full);
    drop      = packet_end & (bad_next | desc_valid);
    commit    = packet_end & ~bad_next & ~desc_valid & (len_next != 8'd0);
    hs        = tx_valid & tx_ready;
    desc_take = desc_valid & ((state == ST_IDLE) | ((state == ST_CHK) & hs));
    rd_next   = rd_ptr + PTR_ONE;
  end

  assign busy = (state != ST_IDLE) | desc_valid;

  always_ff @(posedge clk) begin
    if (byte_acc) mem[wr_ptr[AW-1:0]] <= byte_in;
  end

  // Input side: wr_ptr runs ahead speculatively and rolls back to commit_ptr on a drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      commit_ptr <= '0;
      pend_len   <= '0;
      pend_chk   <= '0;
      pend_bad   <= 1'b0;
      overflow   <= 1'b0;
      desc_valid <= 1'b0;
      desc_len   <= '0;
      desc_chk   <= '0;
    end else begin
      overflow <= drop;
      if (drop)          wr_ptr <= commit_ptr;
      else if (byte_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (commit) commit_ptr <= wr_ptr + {{AW{1'b0}}, byte_acc};
      if (packet_end) begin
        pend_len <= '0;
        pend_chk <= '0;
        pend_bad <= 1'b0;
      end else begin
        pend_len <= len_next;
        pend_chk <= chk_next;
        pend_bad <= bad_next;
      end
      if (commit) begin
        desc_valid <= 1'b1;
        desc_len   <= len_next;
        desc_chk   <= chk_next ^ len_next;
      end else if (desc_take) begin
        desc_valid <= 1'b0;
      end
    end
  end

  // Output FSM: tx_data always holds the byte for the current state, loaded one step early.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      out_len  <= '0;
`ifdef FRAMER_CRC8_EN
      crc      <= '0;
`else
      out_chk  <= '0;
`endif
    end else begin
      if (desc_take) begin
        state    <= ST_SYNC;
        tx_valid <= 1'b1;
        tx_data  <= SYNC_BYTE;
        cnt      <= desc_len;
        out_len  <= desc_len;
`ifdef FRAMER_CRC8_EN
        crc      <= crc8_byte(8'd0, desc_len);
`else
        out_chk  <= desc_chk;
`endif
      end else if (hs) begin
        case (state)
          ST_SYNC: begin
            state   <= ST_LEN;
            tx_data <= out_len;
          end
          ST_LEN: begin
            state   <= ST_DATA;
            tx_data <= mem[rd_ptr[AW-1:0]];
          end
          ST_DATA: begin
            rd_ptr <= rd_next;
            cnt    <= cnt - 8'd1;
`ifdef FRAMER_CRC8_EN
            crc    <= crc8_byte(crc, tx_data);
`endif
            if (cnt == 8'd1) begin
              state <= ST_CHK;
`ifdef FRAMER_CRC8_EN
              tx_data <= crc8_byte(crc, tx_data);
`else
              tx_data <= out_chk;
`endif
            end else begin
              tx_data <= mem[rd_next[AW-1:0]];
            end
          end
          ST_CHK: begin
            state    <= ST_IDLE;
            tx_valid <= 1'b0;
            tx_data  <= '0;
          end
          default: begin
            state    <= ST_IDLE;
            tx_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
